meco_pin_control: RTL

Per-pin output sequencer downstream of the command fetch/decode stage. It accepts decoded pin commands over a valid/ready handshake and drives one physical pin as high-Z, a constant level, or a programmable square wave. It also returns a synchronized input sample plus a rising-edge count over a valid/ready read channel. One instance exists per experiment pin; the decoder fans commands out by pin index.

---
 rtl/meco_pin_control_if.sv | 28 ++
 rtl/meco_pin_control.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/meco_pin_control_if.sv
// ============================================================================
// meco_pin_control_if
// Command and sample-read channels between the pin decoder and one pin sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface meco_pin_control_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rd_ready,
        input  cmd_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rd_ready,
        output cmd_ready, rd_valid, rd_data
    );
endinterface

`default_nettype wire

// File: rtl/meco_pin_control.sv
// ============================================================================
// meco_pin_control
// Per-pin sequencer: high-Z / constant / square-wave drive plus sampled edge count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module meco_pin_control #(
    parameter int COUNT_WIDTH = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    meco_pin_control_if.slave  bus,
    input  wire logic          pin_in,
    output logic               pin_out,
    output logic               pin_oe
);

    localparam logic [2:0] C_OP_CONST  = 3'd1;
    localparam logic [2:0] C_OP_HIGH_T = 3'd2;
    localparam logic [2:0] C_OP_LOW_T  = 3'd3;
    localparam logic [2:0] C_OP_SQUARE = 3'd4;
    localparam logic [2:0] C_OP_STOP   = 3'd5;
    localparam logic [2:0] C_OP_SAMPLE = 3'd6;

    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_CONST   = 2'd1;
    localparam logic [1:0] C_SQ_HIGH = 2'd2;
    localparam logic [1:0] C_SQ_LOW  = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] C_ONE     = COUNT_WIDTH'(1);
    localparam logic [14:0]            C_SAT_MAX = 15'h7FFF;

    logic [1:0]             r_state, w_state_nxt;
    logic                   r_level, w_level_nxt;
    logic [COUNT_WIDTH-1:0] r_high_t, w_high_t_nxt;
    logic [COUNT_WIDTH-1:0] r_low_t, w_low_t_nxt;
    logic [COUNT_WIDTH-1:0] r_low_cur, w_low_cur_nxt;
    logic [COUNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [COUNT_WIDTH-1:0] w_operand;
    logic                   r_sync1, r_pin_sync, r_sync_prev;
    logic                   w_rise;
    logic [14:0]            r_edge_count, w_edge_inc;
    logic                   r_rd_valid;
    logic [15:0]            r_rd_data;
    logic                   w_accept, w_sample;

    assign bus.cmd_ready = ~r_rd_valid;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;

    assign w_accept  = bus.cmd_valid & ~r_rd_valid;
    assign w_sample  = w_accept && (bus.cmd_op == C_OP_SAMPLE);
    assign w_operand = (bus.cmd_data[COUNT_WIDTH-1:0] == '0) ? C_ONE
                                                             : bus.cmd_data[COUNT_WIDTH-1:0];

    assign w_rise     = r_pin_sync & ~r_sync_prev;
    assign w_edge_inc = (w_rise && (r_edge_count != C_SAT_MAX)) ? r_edge_count + 15'd1
                                                                 : r_edge_count;

    // The low duration is snapshotted whenever a high phase starts, so a LOW_T
    // written mid-period only shapes the following periods.
    always_comb begin
        w_state_nxt   = r_state;
        w_level_nxt   = r_level;
        w_cnt_nxt     = r_cnt;
        w_low_cur_nxt = r_low_cur;
        w_high_t_nxt  = r_high_t;
        w_low_t_nxt   = r_low_t;

        case (r_state)
            C_SQ_HIGH: begin
                if (r_cnt <= C_ONE) begin
                    w_state_nxt = C_SQ_LOW;
                    w_cnt_nxt   = r_low_cur;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            C_SQ_LOW: begin
                if (r_cnt <= C_ONE) begin
                    w_state_nxt   = C_SQ_HIGH;
                    w_cnt_nxt     = r_high_t;
                    w_low_cur_nxt = r_low_t;
                end else begin
                    w_cnt_nxt     = r_cnt - C_ONE;
                end
            end
            default: ;
        endcase

        if (w_accept) begin
            case (bus.cmd_op)
                C_OP_CONST: begin
                    w_state_nxt = C_CONST;
                    w_level_nxt = bus.cmd_data[0];
                end
                C_OP_HIGH_T: w_high_t_nxt = w_operand;
                C_OP_LOW_T:  w_low_t_nxt  = w_operand;
                C_OP_SQUARE: begin
                    w_state_nxt   = C_SQ_HIGH;
                    w_cnt_nxt     = r_high_t;
                    w_low_cur_nxt = r_low_t;
                end
                C_OP_STOP:   w_state_nxt = C_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= C_IDLE;
            r_level   <= 1'b0;
            r_high_t  <= C_ONE;
            r_low_t   <= C_ONE;
            r_low_cur <= C_ONE;
            r_cnt     <= '0;
            pin_out   <= 1'b0;
            pin_oe    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_level   <= w_level_nxt;
            r_high_t  <= w_high_t_nxt;
            r_low_t   <= w_low_t_nxt;
            r_low_cur <= w_low_cur_nxt;
            r_cnt     <= w_cnt_nxt;
            pin_oe    <= (w_state_nxt != C_IDLE);
            pin_out   <= (w_state_nxt == C_SQ_HIGH) ||
                         ((w_state_nxt == C_CONST) && w_level_nxt);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1      <= 1'b0;
            r_pin_sync   <= 1'b0;
            r_sync_prev  <= 1'b0;
            r_edge_count <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_sync1     <= pin_in;
            r_pin_sync  <= r_sync1;
            r_sync_prev <= r_pin_sync;
            if (w_sample) begin
                r_edge_count <= {14'd0, w_rise};
                r_rd_data    <= {w_edge_inc, r_pin_sync};
                r_rd_valid   <= 1'b1;
            end else begin
                r_edge_count <= w_edge_inc;
                if (r_rd_valid && bus.rd_ready) begin
                    r_rd_valid <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire
